// File: rtl/imem_loader.sv
// imem_loader: loads a count-prefixed, XOR-checksummed byte stream into instruction memory.
// The CPU is held until the image has been written and its checksum verified.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] widx;
    logic [7:0]  hi;
    logic [7:0]  csum;
    logic        take;
    logic [15:0] n_new;

    assign take     = in_valid && in_ready;
    assign n_new    = {hi, in_byte};
    assign in_ready = state != S_DONE && state != S_ERROR;
    assign cpu_hold = state != S_DONE;
    assign done     = state == S_DONE;
    assign error    = state == S_ERROR;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_CNT_HI;
            count     <= '0;
            widx      <= '0;
            hi        <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (take) begin
                case (state)
                    S_CNT_HI: begin
                        hi    <= in_byte;
                        csum  <= csum ^ in_byte;
                        state <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        count <= n_new;
                        csum  <= csum ^ in_byte;
                        state <= n_new == 16'd0 ? S_CHECK :
                                 32'(n_new) > DEPTH ? S_ERROR : S_DATA_HI;
                    end
                    S_DATA_HI: begin
                        hi    <= in_byte;
                        csum  <= csum ^ in_byte;
                        state <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= widx[ADDR_W-1:0];
                        mem_wdata <= {hi, in_byte};
                        widx      <= widx + 16'd1;
                        csum      <= csum ^ in_byte;
                        // widx still names the word being written, so +1 is the words-written total
                        state     <= widx + 16'd1 == count ? S_CHECK : S_DATA_HI;
                    end
                    S_CHECK: state <= in_byte == csum ? S_DONE : S_ERROR;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives directed and random load streams and compares the write
// sequence and final status against a stream-level reference model.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        in_byte = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;
    logic [31:0] got_w[$];

    always #5 clock = ~clock;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always @(negedge clock) if (mem_we) got_w.push_back(32'({mem_addr, mem_wdata}));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected writes, outcome and number of bytes the loader will accept for a stream.
    task automatic model(input bq_t s, output wq_t w, output logic d, output logic e, output int used);
        int n;
        logic [7:0] x;
        w = {};
        n = int'({s[0], s[1]});
        x = s[0] ^ s[1];
        if (n > DEPTH) begin
            d = 1'b0;
            e = 1'b1;
            used = 2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w.push_back(32'({k[ADDR_W-1:0], s[2+2*k], s[3+2*k]}));
            x ^= s[2+2*k] ^ s[3+2*k];
        end
        used = 2 * n + 3;
        d = s[used-1] == x;
        e = !d;
    endtask

    function automatic bq_t gen(input int n, input bit good);
        bq_t s;
        logic [7:0] x, b;
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        x = s[0] ^ s[1];
        if (n <= DEPTH) begin
            for (int k = 0; k < 2 * n; k++) begin
                b = 8'($urandom);
                s.push_back(b);
                x ^= b;
            end
            s.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
        end
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive(input bq_t s, input int n, input int pct);
        int idx = 0;
        int budget = 0;
        bit hs;
        while (idx < n && budget < 20 * n + 100) begin
            @(negedge clock);
            in_valid = $urandom_range(99) < pct;
            in_byte = in_valid ? s[idx] : 8'($urandom);
            hs = in_valid && in_ready;
            @(posedge clock);
            if (hs) idx++;
            budget++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        check("accepted", idx, n);
    endtask

    task automatic run(input bq_t s, input int pct, input bit rst_first);
        wq_t ew;
        logic ed, ee;
        int used;
        model(s, ew, ed, ee, used);
        if (rst_first) do_reset();
        got_w.delete();
        drive(s, used, pct);
        repeat (3) @(negedge clock);
        check("nwrites", got_w.size(), ew.size());
        foreach (ew[i]) if (i < got_w.size()) check("write", got_w[i], ew[i]);
        check("done", done, ed);
        check("error", error, ee);
        check("cpu_hold", cpu_hold, !ed);
        check("in_ready", in_ready, !(ed || ee));
        check("mem_we_idle", mem_we, 0);
        if (ew.size() > 0) check("hold", 32'({mem_addr, mem_wdata}), ew[ew.size()-1]);
    endtask

    initial begin
        bq_t s;
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);

        // XOR of 00 02 80 01 60 C0 is 0x23
        s = {8'h00, 8'h02, 8'h80, 8'h01, 8'h60, 8'hC0, 8'h23};
        run(s, 100, 1);
        s[6] = 8'h00;
        run(s, 100, 1);
        s = {8'h00, 8'h00, 8'h00};
        run(s, 100, 1);
        s = {8'h04, 8'h01};
        run(s, 100, 1);
        s = {8'h00, 8'h02, 8'h80, 8'h01, 8'h60, 8'hC0, 8'h23};
        run(s, 50, 1);

        do_reset();
        got_w.delete();
        s = {8'h00, 8'h02, 8'h12};
        drive(s, 3, 100);
        in_byte = 8'h34;
        in_valid = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_drop_we", got_w.size(), 0);
        check("rst_mid_ready", in_ready, 1);
        s = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        run(s, 100, 0);

        run(gen(DEPTH, 1'b1), 100, 1);
        run(gen(DEPTH + 1, 1'b1), 100, 1);
        repeat (20) run(gen($urandom_range(0, 8), $urandom_range(0, 2) != 0), $urandom_range(30, 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
